// File: rtl/udp_pkg.sv
// Shared constants and state encoding for the UDP transmit arbiter.
package udp_pkg;

  localparam int ETH_MTU     = 1500;
  localparam int IP_HDR_LEN  = 20;
  localparam int UDP_HDR_LEN = 8;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_START = 4'b0010,
    ST_BUSY  = 4'b0100,
    ST_GAP   = 4'b1000
  } arb_state_t;

endpackage

// File: rtl/udp_tx_arbiter_if.sv
// Requester-side and transmitter-side signals of the UDP transmit arbiter.
interface udp_tx_arbiter_if;

  // Handshakes: req[i] is a level held until done[i] or err[i] pulses for one cycle;
  // rd_en[i] and payload_req_i are single-cycle strobes, data valid in the same cycle.
  logic [1:0]  req;
  logic [31:0] req_len;
  logic [95:0] req_dst_mac;
  logic [63:0] req_dst_ip;
  logic [31:0] req_dst_port;
  logic [1:0]  rd_en;
  logic [15:0] rd_dat;
  logic [1:0]  done;
  logic [1:0]  err;
  logic [1:0]  grant;

  logic        tx_en_pulse;
  logic        tx_done;
  logic [47:0] tx_dst_mac;
  logic [47:0] tx_src_mac;
  logic [31:0] tx_dst_ip;
  logic [31:0] tx_src_ip;
  logic [15:0] tx_dst_port;
  logic [15:0] tx_src_port;
  logic [15:0] tx_data_len;
  logic        payload_req_i;
  logic [7:0]  payload_dat_o;

  modport master (
    input  req, req_len, req_dst_mac, req_dst_ip, req_dst_port, rd_dat,
    input  tx_done, payload_req_i,
    output rd_en, done, err, grant,
    output tx_en_pulse, tx_dst_mac, tx_src_mac, tx_dst_ip, tx_src_ip,
    output tx_dst_port, tx_src_port, tx_data_len, payload_dat_o
  );

  modport slave (
    output req, req_len, req_dst_mac, req_dst_ip, req_dst_port, rd_dat,
    output tx_done, payload_req_i,
    input  rd_en, done, err, grant,
    input  tx_en_pulse, tx_dst_mac, tx_src_mac, tx_dst_ip, tx_src_ip,
    input  tx_dst_port, tx_src_port, tx_data_len, payload_dat_o
  );

endinterface

// File: rtl/udp_tx_arbiter_rr_arb2.sv
// Two-input round-robin pick; the pointer moves past whoever was just served.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic [1:0] served_i,
  output logic [1:0] pick_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    pick_o = 2'b00;
    if (ptr_q) begin
      if (req_i[1])      pick_o = 2'b10;
      else if (req_i[0]) pick_o = 2'b01;
    end else begin
      if (req_i[0])      pick_o = 2'b01;
      else if (req_i[1]) pick_o = 2'b10;
    end
  end

  assign ptr_d = update_i ? (served_i == 2'b01) : ptr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= 1'b0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Two-requester arbiter in front of one UDP transmitter: picks an owner, latches its
// frame fields, streams its payload, and enforces the inter-frame gap.
module udp_tx_arbiter
  import udp_pkg::*;
#(
  parameter int IFG_CYCLES     = 12,
  parameter int MAX_LEN        = ETH_MTU - IP_HDR_LEN - UDP_HDR_LEN,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic        clk_125m,
  input  logic        rst_n,
  input  logic [47:0] src_mac,
  input  logic [31:0] src_ip,
  input  logic [15:0] src_port,
  output logic        busy,
  output arb_state_t  state_o,
  udp_tx_arbiter_if.master arb_if
);

  localparam logic [11:0] TIMEOUT_LAST = 12'(TIMEOUT_CYCLES - 1);
  localparam logic [11:0] IFG_LAST     = 12'(IFG_CYCLES - 1);
  localparam logic [15:0] MAX_LEN_W    = 16'(MAX_LEN);

  arb_state_t  state_q, state_d;
  logic [1:0]  grant_q, grant_d, done_q, done_d, pick, err_now;
  logic [11:0] cnt_q, cnt_d;
  logic        latch_en, rr_update, tx_en, len_ok, win_idx, own_idx;
  logic [47:0] dst_mac_q, src_mac_q;
  logic [31:0] dst_ip_q, src_ip_q;
  logic [15:0] dst_port_q, src_port_q, data_len_q;

  rr_arb2 u_rr (
    .clk_i    (clk_125m),
    .rst_ni   (rst_n),
    .req_i    (arb_if.req),
    .update_i (rr_update),
    .served_i (grant_q),
    .pick_o   (pick)
  );

  assign win_idx = pick[1];
  assign own_idx = grant_q[1];
  assign len_ok  = (data_len_q != 16'd0) && (data_len_q <= MAX_LEN_W);

  // cnt_q is shared: BUSY timeout and GAP length; it restarts at 0 on entry to either.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    cnt_d     = '0;
    done_d    = '0;
    err_now   = '0;
    tx_en     = 1'b0;
    latch_en  = 1'b0;
    rr_update = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_if.req != 2'b00) begin
          state_d  = ST_START;
          grant_d  = pick;
          latch_en = 1'b1;
        end
      end
      ST_START: begin
        if (len_ok) begin
          tx_en   = 1'b1;
          state_d = ST_BUSY;
        end else begin
          err_now = grant_q;
          state_d = ST_GAP;
        end
      end
      ST_BUSY: begin
        if (arb_if.tx_done) begin
          done_d  = grant_q;
          state_d = ST_GAP;
        end else if (cnt_q == TIMEOUT_LAST) begin
          err_now = grant_q;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == IFG_LAST) begin
          state_d   = ST_IDLE;
          grant_d   = '0;
          rr_update = 1'b1;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_125m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      cnt_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk_125m or negedge rst_n) begin
    if (!rst_n) begin
      dst_mac_q  <= '0;
      src_mac_q  <= '0;
      dst_ip_q   <= '0;
      src_ip_q   <= '0;
      dst_port_q <= '0;
      src_port_q <= '0;
      data_len_q <= '0;
    end else if (latch_en) begin
      dst_mac_q  <= win_idx ? arb_if.req_dst_mac[95:48] : arb_if.req_dst_mac[47:0];
      dst_ip_q   <= win_idx ? arb_if.req_dst_ip[63:32] : arb_if.req_dst_ip[31:0];
      dst_port_q <= win_idx ? arb_if.req_dst_port[31:16] : arb_if.req_dst_port[15:0];
      data_len_q <= win_idx ? arb_if.req_len[31:16] : arb_if.req_len[15:0];
      src_mac_q  <= src_mac;
      src_ip_q   <= src_ip;
      src_port_q <= src_port;
    end
  end

  assign busy                 = (state_q != ST_IDLE);
  assign state_o              = state_q;
  assign arb_if.grant         = grant_q;
  assign arb_if.done          = done_q;
  assign arb_if.err           = err_now;
  assign arb_if.tx_en_pulse   = tx_en;
  assign arb_if.rd_en         = (state_q == ST_BUSY && arb_if.payload_req_i) ? grant_q : 2'b00;
  assign arb_if.payload_dat_o = (state_q == ST_BUSY) ? arb_if.rd_dat[{own_idx, 3'b000} +: 8] : 8'h00;
  assign arb_if.tx_dst_mac    = dst_mac_q;
  assign arb_if.tx_src_mac    = src_mac_q;
  assign arb_if.tx_dst_ip     = dst_ip_q;
  assign arb_if.tx_src_ip     = src_ip_q;
  assign arb_if.tx_dst_port   = dst_port_q;
  assign arb_if.tx_src_port   = src_port_q;
  assign arb_if.tx_data_len   = data_len_q;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed bench for udp_tx_arbiter: each step drives inputs just after a rising edge
// and checks outputs mid-cycle against hand-computed values.
module tb_udp_tx_arbiter;
  import udp_pkg::*;

  localparam logic [47:0] SRC_MAC = 48'h000A_3500_0001;
  localparam logic [31:0] SRC_IP  = 32'hC0A8_0001;
  localparam logic [15:0] SRC_PRT = 16'd5000;
  localparam logic [47:0] MAC0    = 48'h0200_0000_00AA;
  localparam logic [47:0] MAC1    = 48'h0200_0000_00BB;
  localparam logic [31:0] IP0     = 32'hC0A8_000A;
  localparam logic [31:0] IP1     = 32'hC0A8_000B;
  localparam logic [15:0] PRT0    = 16'd1234;
  localparam logic [15:0] PRT1    = 16'd4321;

  logic        clk_125m = 1'b0;
  logic        rst_n;
  logic [47:0] src_mac;
  logic [31:0] src_ip;
  logic [15:0] src_port;
  logic        busy;
  arb_state_t  state;
  int          n_vec = 0;
  int          n_miss = 0;
  int          pulses;
  int          nb;
  logic        preq;

  udp_tx_arbiter_if ifc ();

  udp_tx_arbiter dut (
    .clk_125m (clk_125m),
    .rst_n    (rst_n),
    .src_mac  (src_mac),
    .src_ip   (src_ip),
    .src_port (src_port),
    .busy     (busy),
    .state_o  (state),
    .arb_if   (ifc)
  );

  always #4 clk_125m = ~clk_125m;

  task automatic adv(input int n = 1);
    repeat (n) @(posedge clk_125m);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_start(input string tag, input logic [1:0] g, input logic [15:0] len,
                           input logic [47:0] mac, input logic [31:0] ip, input logic [15:0] prt);
    chk({tag, "_state"}, 64'(state), 64'(ST_START));
    chk({tag, "_grant"}, 64'(ifc.grant), 64'(g));
    chk({tag, "_tx_en"}, 64'(ifc.tx_en_pulse), 64'd1);
    chk({tag, "_len"}, 64'(ifc.tx_data_len), 64'(len));
    chk({tag, "_dmac"}, 64'(ifc.tx_dst_mac), 64'(mac));
    chk({tag, "_dip"}, 64'(ifc.tx_dst_ip), 64'(ip));
    chk({tag, "_dport"}, 64'(ifc.tx_dst_port), 64'(prt));
  endtask

  initial begin
    rst_n             = 1'b0;
    src_mac           = SRC_MAC;
    src_ip            = SRC_IP;
    src_port          = SRC_PRT;
    ifc.req           = 2'b00;
    ifc.req_len       = '0;
    ifc.req_dst_mac   = {MAC1, MAC0};
    ifc.req_dst_ip    = {IP1, IP0};
    ifc.req_dst_port  = {PRT1, PRT0};
    ifc.rd_dat        = '0;
    ifc.tx_done       = 1'b0;
    ifc.payload_req_i = 1'b0;

    // Reset values
    adv(2);
    chk("rst_state", 64'(state), 64'(ST_IDLE));
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(ifc.grant), 64'd0);
    chk("rst_tx_en", 64'(ifc.tx_en_pulse), 64'd0);
    chk("rst_done", 64'(ifc.done), 64'd0);
    chk("rst_err", 64'(ifc.err), 64'd0);
    chk("rst_rd_en", 64'(ifc.rd_en), 64'd0);
    chk("rst_dmac", 64'(ifc.tx_dst_mac), 64'd0);
    chk("rst_smac", 64'(ifc.tx_src_mac), 64'd0);
    chk("rst_len", 64'(ifc.tx_data_len), 64'd0);
    rst_n = 1'b1;
    adv();

    // Single frame from requester 0, 64 bytes
    ifc.req_len = {16'd100, 16'd64};
    ifc.req     = 2'b01;
    settle();
    chk("s1_idle_tx_en", 64'(ifc.tx_en_pulse), 64'd0);
    adv();
    chk_start("s1", 2'b01, 16'd64, MAC0, IP0, PRT0);
    chk("s1_smac", 64'(ifc.tx_src_mac), 64'(SRC_MAC));
    chk("s1_sip", 64'(ifc.tx_src_ip), 64'(SRC_IP));
    chk("s1_sport", 64'(ifc.tx_src_port), 64'(SRC_PRT));
    ifc.req_len[15:0] = 16'd7;
    ifc.req           = 2'b00;
    adv();
    pulses = 0;
    for (int i = 0; i < 72; i++) begin
      preq              = (i % 9 != 8);
      ifc.payload_req_i = preq;
      ifc.rd_dat        = {8'h55, 8'(i + 16)};
      settle();
      chk("s1_rd_en", 64'(ifc.rd_en), 64'({1'b0, preq}));
      chk("s1_pdat", 64'(ifc.payload_dat_o), 64'(8'(i + 16)));
      pulses += int'(ifc.rd_en[0]);
      if (i == 0) chk("s1_busy_tx_en", 64'(ifc.tx_en_pulse), 64'd0);
      adv();
    end
    chk("s1_rd_pulses", 64'(pulses), 64'd64);
    chk("s1_len_held", 64'(ifc.tx_data_len), 64'd64);
    ifc.payload_req_i = 1'b0;
    ifc.tx_done       = 1'b1;
    settle();
    chk("s1_done_early", 64'(ifc.done), 64'd0);
    chk("s1_state_busy", 64'(state), 64'(ST_BUSY));
    adv();
    ifc.tx_done = 1'b0;
    chk("s1_done", 64'(ifc.done), 64'd1);
    chk("s1_gap_state", 64'(state), 64'(ST_GAP));
    chk("s1_gap_grant", 64'(ifc.grant), 64'd1);
    chk("s1_gap_rd_en", 64'(ifc.rd_en), 64'd0);
    chk("s1_gap_pdat", 64'(ifc.payload_dat_o), 64'd0);
    ifc.req = 2'b10;
    for (int g = 2; g <= 12; g++) begin
      adv();
      ifc.tx_done = (g == 5);
      settle();
      chk("s1_gap_hold", 64'(state), 64'(ST_GAP));
    end
    ifc.tx_done = 1'b0;
    adv();
    chk("s1_idle_after_gap", 64'(state), 64'(ST_IDLE));
    chk("s1_idle_grant", 64'(ifc.grant), 64'd0);
    chk("s1_idle_busy", 64'(busy), 64'd0);
    chk("s1_no_extra_done", 64'(ifc.done), 64'd0);
    adv();
    chk_start("s1b", 2'b10, 16'd100, MAC1, IP1, PRT1);
    adv();
    ifc.payload_req_i = 1'b1;
    ifc.rd_dat        = 16'hC33C;
    settle();
    chk("s1b_rd_en", 64'(ifc.rd_en), 64'd2);
    chk("s1b_pdat", 64'(ifc.payload_dat_o), 64'hC3);
    ifc.payload_req_i = 1'b0;
    adv();
    ifc.tx_done = 1'b1;
    adv();
    ifc.tx_done = 1'b0;
    chk("s1b_done", 64'(ifc.done), 64'd2);
    ifc.req = 2'b00;
    adv(12);
    chk("s1b_idle", 64'(state), 64'(ST_IDLE));
    ifc.tx_done = 1'b1;
    adv();
    ifc.tx_done = 1'b0;
    chk("idle_tx_done_state", 64'(state), 64'(ST_IDLE));
    chk("idle_tx_done_done", 64'(ifc.done), 64'd0);

    // Both requesting, pointer at 0: requester 0 first, then 1
    ifc.req_len = {16'd100, 16'd18};
    ifc.req     = 2'b11;
    adv();
    chk_start("s2a", 2'b01, 16'd18, MAC0, IP0, PRT0);
    adv(2);
    ifc.tx_done = 1'b1;
    adv();
    ifc.tx_done = 1'b0;
    chk("s2a_done", 64'(ifc.done), 64'd1);
    ifc.req = 2'b10;
    for (int k = 0; k < 12; k++) begin
      adv();
      chk("s2_grant_onehot0", 64'($onehot0(ifc.grant)), 64'd1);
    end
    chk("s2_idle", 64'(state), 64'(ST_IDLE));
    adv();
    chk_start("s2b", 2'b10, 16'd100, MAC1, IP1, PRT1);
    adv();
    ifc.tx_done = 1'b1;
    adv();
    ifc.tx_done = 1'b0;
    chk("s2b_done", 64'(ifc.done), 64'd2);
    ifc.req = 2'b00;
    adv(12);
    chk("s2b_idle_busy", 64'(busy), 64'd0);

    // Invalid lengths 0 and 1473, then boundary 1472
    for (int t = 0; t < 2; t++) begin
      ifc.req_len = {16'd100, (t == 0) ? 16'd0 : 16'd1473};
      ifc.req     = 2'b01;
      adv();
      chk("s3_err", 64'(ifc.err), 64'd1);
      chk("s3_tx_en", 64'(ifc.tx_en_pulse), 64'd0);
      chk("s3_busy", 64'(busy), 64'd1);
      ifc.req = 2'b00;
      nb = 1;
      for (int k = 0; k < 20 && busy; k++) begin
        adv();
        if (busy) nb++;
        if (k == 0) chk("s3_err_once", 64'(ifc.err), 64'd0);
      end
      chk("s3_busy_cycles", 64'(nb), 64'd13);
    end
    ifc.req_len = {16'd100, 16'd1472};
    ifc.req     = 2'b01;
    adv();
    chk_start("s3max", 2'b01, 16'd1472, MAC0, IP0, PRT0);
    chk("s3max_err", 64'(ifc.err), 64'd0);
    ifc.req = 2'b00;
    adv();
    ifc.tx_done = 1'b1;
    adv();
    ifc.tx_done = 1'b0;
    chk("s3max_done", 64'(ifc.done), 64'd1);
    adv(12);

    // Timeout with tx_done withheld, then tx_done on the timeout cycle
    for (int t = 0; t < 2; t++) begin
      ifc.req_len = {16'd100, 16'd50};
      ifc.req     = 2'b01;
      adv();
      chk("s4_tx_en", 64'(ifc.tx_en_pulse), 64'd1);
      ifc.req = 2'b00;
      adv(4094);
      chk("s4_err_before", 64'(ifc.err), 64'd0);
      chk("s4_state_before", 64'(state), 64'(ST_BUSY));
      adv();
      ifc.tx_done = (t == 1);
      settle();
      chk("s4_err_at_to", 64'(ifc.err), (t == 0) ? 64'd1 : 64'd0);
      adv();
      ifc.tx_done = 1'b0;
      chk("s4_gap", 64'(state), 64'(ST_GAP));
      chk("s4_done", 64'(ifc.done), (t == 0) ? 64'd0 : 64'd1);
      chk("s4_err_after", 64'(ifc.err), 64'd0);
      adv(12);
      chk("s4_idle", 64'(state), 64'(ST_IDLE));
    end

    // Reset during BUSY, then a fresh request from requester 1
    ifc.req_len = {16'd100, 16'd1000};
    ifc.req     = 2'b01;
    adv();
    chk("s6_tx_en", 64'(ifc.tx_en_pulse), 64'd1);
    adv();
    ifc.payload_req_i = 1'b1;
    adv(3);
    chk("s6_rd_en", 64'(ifc.rd_en), 64'd1);
    rst_n = 1'b0;
    settle();
    chk("s6_rst_state", 64'(state), 64'(ST_IDLE));
    chk("s6_rst_busy", 64'(busy), 64'd0);
    chk("s6_rst_grant", 64'(ifc.grant), 64'd0);
    chk("s6_rst_rd_en", 64'(ifc.rd_en), 64'd0);
    chk("s6_rst_pdat", 64'(ifc.payload_dat_o), 64'd0);
    chk("s6_rst_len", 64'(ifc.tx_data_len), 64'd0);
    chk("s6_rst_dmac", 64'(ifc.tx_dst_mac), 64'd0);
    ifc.req           = 2'b00;
    ifc.payload_req_i = 1'b0;
    adv();
    chk("s6_rst_done", 64'(ifc.done), 64'd0);
    chk("s6_rst_err", 64'(ifc.err), 64'd0);
    rst_n = 1'b1;
    adv();
    chk("s6_post_done", 64'(ifc.done), 64'd0);
    chk("s6_post_busy", 64'(busy), 64'd0);
    ifc.req = 2'b10;
    adv();
    chk_start("s6b", 2'b10, 16'd100, MAC1, IP1, PRT1);
    adv();
    ifc.tx_done = 1'b1;
    adv();
    ifc.tx_done = 1'b0;
    chk("s6b_done", 64'(ifc.done), 64'd2);
    ifc.req = 2'b00;
    adv(12);
    chk("s6b_idle", 64'(state), 64'(ST_IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/udp_tx_arbiter.md
UDP_TX_ARBITER -- requirements
Module: udp_tx_arbiter

Interface
REQ-001 Parameter IFG_CYCLES, 12, idle cycles enforced after each frame or rejection before the next grant.
REQ-002 Parameter MAX_LEN, 1472, largest accepted payload length in bytes.
REQ-003 Parameter TIMEOUT_CYCLES, 4095, cycles allowed from tx_en_pulse to tx_done before abort.
REQ-004 Port clk_125m  in  1  sole clock, all logic rising-edge.
REQ-005 Port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 Port req  in  2  per-requester frame request, level, held until own done/err pulse.
REQ-007 Port req_len  in  32  payload length; requester i at [16i+15:16i].
REQ-008 Port req_dst_mac  in  96  destination MAC; requester i at [48i+47:48i].
REQ-009 Port req_dst_ip  in  64  destination IP; requester i at [32i+31:32i].
REQ-010 Port req_dst_port  in  32  destination UDP port; requester i at [16i+15:16i].
REQ-011 Port src_mac / src_ip / src_port  in  48/32/16  local addresses, quasi-static.
REQ-012 Port rd_en  out  2  payload byte request to requester i (first-word-fall-through source).
REQ-013 Port rd_dat  in  16  payload byte from requester i at [8i+7:8i], valid in the same cycle as rd_en.
REQ-014 Port done / err  out  2 / 2  one-cycle completion / rejection-or-abort pulse per requester.
REQ-015 Port grant  out  2  one-hot owner of the transmitter, 0 when unowned.
REQ-016 Port busy  out  1  high in any state other than IDLE.
REQ-017 Port tx_en_pulse  out  1  one-cycle frame start to the UDP transmitter.
REQ-018 Port tx_done  in  1  one-cycle end-of-frame from the UDP transmitter.
REQ-019 Port tx_dst_mac/tx_src_mac/tx_dst_ip/tx_src_ip/tx_dst_port/tx_src_port/tx_data_len  out  48/48/32/32/16/16/16  frame fields to the transmitter, registered.
REQ-020 Port payload_req_i  in  1  transmitter byte request; payload_dat_o  out  8  byte returned in the same cycle.

Function
REQ-021 States IDLE, START, BUSY, GAP; one-hot encoding.
REQ-022 IDLE: if req != 0, winner chosen round-robin: requester indicated by rr_ptr wins if requesting, otherwise the other one.
REQ-023 IDLE->START on any req; in that edge grant and all tx_* fields latch from the winner's inputs (src fields from src_*).
REQ-024 Fields and grant remain constant from START through the end of GAP; requester input changes after latch are ignored.
REQ-025 START lasts one cycle; tx_en_pulse high exactly during START when length valid (1..MAX_LEN), START->BUSY.
REQ-026 Length 0 or > MAX_LEN: no tx_en_pulse, err[winner] pulses in the START cycle, START->GAP.
REQ-027 BUSY: rd_en[grant] = payload_req_i combinationally, other rd_en bit 0; payload_dat_o = rd_dat of granted requester; both 0 outside BUSY.
REQ-028 BUSY->GAP on tx_done; done[grant] pulses the cycle after tx_done is sampled.
REQ-029 BUSY timeout counter (12 bits) clears on entry, increments each cycle; reaching TIMEOUT_CYCLES -> err[grant] pulse, BUSY->GAP.
REQ-030 tx_done coincident with timeout: tx_done wins, done pulses, no err.
REQ-031 GAP: counter runs IFG_CYCLES cycles, then GAP->IDLE, grant cleared, rr_ptr set to the non-granted requester.
REQ-032 tx_done outside BUSY is ignored; req deassertion mid-frame does not abort the frame.
REQ-033 Both requesters simultaneously in IDLE: rr_ptr winner; the other is served next, no starvation.

Reset
REQ-034 rst_n low: state IDLE, rr_ptr 0, grant 0, busy 0, tx_en_pulse 0, done 0, err 0, all tx_* fields 0, counters 0.
REQ-035 Reset mid-frame returns to IDLE immediately; no done/err is produced for the aborted frame.

Structure
REQ-036 State encodings and the UDP/IP header overhead constants (8, 20) shall live in a shared package udp_pkg.
REQ-037 One sub-module is natural: rr_arb2 (2-input round-robin pick with pointer update); the rest is flat.

Verification
REQ-038 req=01, len0=64: tx_en_pulse one cycle after req; 64 rd_en[0] pulses mirror payload_req_i; done[0] the cycle after tx_done; no next grant for 12 cycles.
REQ-039 req=11, rr_ptr=0, lengths 18/100: requester 0 framed first, requester 1 granted after the gap; grant never 11.
REQ-040 len0=0 and, separately, len0=1473: err[0] pulse, tx_en_pulse stays 0, busy high for 13 cycles.
REQ-041 tx_done withheld: err[grant] pulses 4095 cycles after tx_en_pulse, state reaches IDLE after the gap.
REQ-042 tx_done on the timeout cycle: done pulses, err stays 0.
REQ-043 rst_n low during BUSY with len0=1000: all outputs 0 next edge; a fresh req=10 afterwards is served normally.
